hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit_pkg.sv | 16 +
 rtl/hazard_fwd_unit_compare.sv | 33 +++
 rtl/hazard_fwd_unit.sv | 108 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared CPU pipeline definitions: operand-select codes and hazard tag layout.
package hazard_fwd_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned TAG_REGW = 5;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
  } tag_flags_t;

endpackage

// File: rtl/hazard_fwd_unit_compare.sv
// Operand select for one EX source: MEM-stage producer wins over WB-stage producer.
module fwd_compare
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs_i,
  input  logic            rs_used_i,
  input  tag_flags_t      mem_tag_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  tag_flags_t      wb_tag_i,
  input  logic [REGW-1:0] wb_rd_i,
  output logic [1:0]      sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = rs_used_i & mem_tag_i.valid & mem_tag_i.regwrite &
                   (mem_rd_i != '0) & (mem_rd_i == rs_i);
  assign wb_hit  = rs_used_i & wb_tag_i.valid & wb_tag_i.regwrite &
                   (wb_rd_i != '0) & (wb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: tracks EX/MEM/WB tags, issues
// one-cycle load-use stalls and drives the EX operand-select codes.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            ex_flush,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            stall_if_id,
  output logic            bubble_ex,
  output logic [CNTW-1:0] stall_count
);

  tag_flags_t      ex_tag_q, ex_tag_d, mem_tag_q, wb_tag_q;
  logic [REGW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q, mem_rd_q, wb_rd_q;
  logic            ex_rs1_used_q, ex_rs2_used_q;
  logic [CNTW-1:0] stall_count_q, stall_count_d;
  logic            load_use;
  logic            unused_tag_bits;

  // Load result is not available until MEM completes, so a dependent ID
  // instruction must wait one cycle behind a load sitting in EX.
  assign load_use = ex_tag_q.valid & ex_tag_q.is_load & (ex_rd_q != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == ex_rd_q)) |
                     (id_rs2_used & (id_rs2 == ex_rd_q)));

  assign stall_if_id = rst_n & load_use & ~ex_flush;
  assign bubble_ex   = rst_n & (load_use | ex_flush);
  assign stall_count = stall_count_q;

  assign unused_tag_bits = ^{mem_tag_q.is_load, wb_tag_q.is_load};

  always_comb begin
    ex_tag_d = '{valid: id_valid, regwrite: id_regwrite, is_load: id_is_load};
    if (bubble_ex) begin
      ex_tag_d.valid = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_if_id && (stall_count_q != {CNTW{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag_q      <= '0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      mem_tag_q     <= '0;
      mem_rd_q      <= '0;
      wb_tag_q      <= '0;
      wb_rd_q       <= '0;
      stall_count_q <= '0;
    end else begin
      ex_tag_q      <= ex_tag_d;
      ex_rd_q       <= id_rd;
      ex_rs1_q      <= id_rs1;
      ex_rs2_q      <= id_rs2;
      ex_rs1_used_q <= id_rs1_used;
      ex_rs2_used_q <= id_rs2_used;
      mem_tag_q     <= ex_tag_q;
      mem_rd_q      <= ex_rd_q;
      wb_tag_q      <= mem_tag_q;
      wb_rd_q       <= mem_rd_q;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_compare #(.REGW(REGW)) u_cmp_a (
    .rs_i      (ex_rs1_q),
    .rs_used_i (ex_tag_q.valid & ex_rs1_used_q),
    .mem_tag_i (mem_tag_q),
    .mem_rd_i  (mem_rd_q),
    .wb_tag_i  (wb_tag_q),
    .wb_rd_i   (wb_rd_q),
    .sel_o     (fwd_a_sel)
  );

  fwd_compare #(.REGW(REGW)) u_cmp_b (
    .rs_i      (ex_rs2_q),
    .rs_used_i (ex_tag_q.valid & ex_rs2_used_q),
    .mem_tag_i (mem_tag_q),
    .mem_rd_i  (mem_rd_q),
    .wb_tag_i  (wb_tag_q),
    .wb_rd_i   (wb_rd_q),
    .sel_o     (fwd_b_sel)
  );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: instruction-history model plus
// directed hazard scenarios with literal expectations.
module tb_hazard_fwd_unit;

  localparam int REGW = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [REGW-1:0] id_rs1 = '0;
  logic [REGW-1:0] id_rs2 = '0;
  logic            id_rs1_used = 1'b0;
  logic            id_rs2_used = 1'b0;
  logic [REGW-1:0] id_rd = '0;
  logic            id_regwrite = 1'b0;
  logic            id_is_load = 1'b0;
  logic            ex_flush = 1'b0;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            stall_if_id;
  logic            bubble_ex;
  logic [CNTW-1:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  hazard_fwd_unit #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .ex_flush    (ex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Instructions in flight: index 0 is in EX, 1 in MEM, 2 in WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } ins_t;

  ins_t hist[$];
  int   m_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic ins_t nop_ins();
    ins_t n;
    n = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0, rs1: 0, rs2: 0, u1: 1'b0, u2: 1'b0};
    return n;
  endfunction

  // Youngest older writer of the source register supplies the operand.
  function automatic int m_fwd(bit second);
    int rs;
    bit used;
    if (!rst_n || !hist[0].v) return 0;
    rs   = second ? hist[0].rs2 : hist[0].rs1;
    used = second ? hist[0].u2 : hist[0].u1;
    if (!used || rs == 0) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (hist[k].v && hist[k].rw && hist[k].rd == rs) return k;
    end
    return 0;
  endfunction

  function automatic bit m_load_use();
    int r;
    if (!rst_n || !hist[0].v || !hist[0].ld || hist[0].rd == 0 || !id_valid) return 1'b0;
    r = hist[0].rd;
    return (id_rs1_used && int'(id_rs1) == r) || (id_rs2_used && int'(id_rs2) == r);
  endfunction

  function automatic bit m_stall();
    return m_load_use() && !ex_flush;
  endfunction

  function automatic bit m_bubble();
    return rst_n && (m_load_use() || ex_flush);
  endfunction

  initial begin
    hist = '{nop_ins(), nop_ins(), nop_ins()};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist  = '{nop_ins(), nop_ins(), nop_ins()};
        m_cnt = 0;
      end else begin
        ins_t n;
        bit   st;
        bit   bb;
        st = m_stall();
        bb = m_bubble();
        n  = '{v: id_valid && !bb, rd: int'(id_rd), rw: id_regwrite, ld: id_is_load,
               rs1: int'(id_rs1), rs2: int'(id_rs2), u1: id_rs1_used, u2: id_rs2_used};
        if (st && m_cnt < (1 << CNTW) - 1) m_cnt++;
        hist.push_front(n);
        void'(hist.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_fwd_a", int'(fwd_a_sel), m_fwd(1'b0));
      check("model_fwd_b", int'(fwd_b_sel), m_fwd(1'b1));
      check("model_stall", int'(stall_if_id), int'(m_stall()));
      check("model_bubble", int'(bubble_ex), int'(m_bubble()));
      check("model_count", int'(stall_count), m_cnt);
    end
  end

  task automatic drive(input bit v, input int rd, input bit rw, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2, input bit fl);
    id_valid    = v;
    id_rd       = REGW'(rd);
    id_regwrite = rw;
    id_is_load  = ld;
    id_rs1      = REGW'(rs1);
    id_rs1_used = u1;
    id_rs2      = REGW'(rs2);
    id_rs2_used = u2;
    ex_flush    = fl;
  endtask

  // One cycle with the given instruction in ID; returns just after the falling edge.
  task automatic step(input bit v, input int rd, input bit rw, input bit ld,
                      input int rs1, input bit u1, input int rs2, input bit u2, input bit fl);
    @(posedge clk);
    #1;
    drive(v, rd, rw, ld, rs1, u1, rs2, u2, fl);
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic one_load_stall();
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 7, 1, 0, 0, 0);
    check("chain_stall_on", int'(stall_if_id), 1);
    step(1, 9, 1, 0, 7, 1, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_fwd_a", int'(fwd_a_sel), 0);
    check("rst_fwd_b", int'(fwd_b_sel), 0);
    check("rst_stall", int'(stall_if_id), 0);
    check("rst_bubble", int'(bubble_ex), 0);
    check("rst_count", int'(stall_count), 0);
    #20;
    rst_n = 1'b1;
    nop();
    check("post_rst_bubble", int'(bubble_ex), 0);

    // add x5 then consumer of x5 on rs1
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 6, 1, 0, 5, 1, 3, 1, 0);
    nop();
    check("mem_fwd_a", int'(fwd_a_sel), 1);
    check("mem_fwd_b", int'(fwd_b_sel), 0);

    // x5 in both MEM and WB
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 5, 1, 0);
    nop();
    check("prio_fwd_b", int'(fwd_b_sel), 1);

    // MEM holds a bubble, WB holds x5
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    nop();
    step(1, 6, 1, 0, 0, 0, 5, 1, 0);
    nop();
    check("wb_fwd_b", int'(fwd_b_sel), 2);

    // lw x7 followed by a consumer of x7
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 8, 1, 0, 7, 1, 0, 0, 0);
    check("lu_stall", int'(stall_if_id), 1);
    check("lu_bubble", int'(bubble_ex), 1);
    check("lu_count0", int'(stall_count), 0);
    step(1, 8, 1, 0, 7, 1, 0, 0, 0);
    check("lu_stall_once", int'(stall_if_id), 0);
    check("lu_count1", int'(stall_count), 1);
    nop();
    check("lu_fwd_a_wb", int'(fwd_a_sel), 2);

    // same load-use but squashed by a flush
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 8, 1, 0, 7, 1, 0, 0, 1);
    check("flush_stall", int'(stall_if_id), 0);
    check("flush_bubble", int'(bubble_ex), 1);
    nop();
    check("flush_count", int'(stall_count), 1);

    // x0 producer, including a load
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 8, 1, 0, 0, 1, 0, 1, 0);
    check("x0_stall", int'(stall_if_id), 0);
    check("x0_bubble", int'(bubble_ex), 0);
    nop();
    check("x0_fwd_a", int'(fwd_a_sel), 0);

    // load chain: lw x7; lw x8 <- x7; add <- x8
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 8, 1, 1, 7, 1, 0, 0, 0);
    check("chain1_stall", int'(stall_if_id), 1);
    step(1, 8, 1, 1, 7, 1, 0, 0, 0);
    check("chain1_release", int'(stall_if_id), 0);
    step(1, 9, 1, 0, 8, 1, 0, 0, 0);
    check("chain2_stall", int'(stall_if_id), 1);
    step(1, 9, 1, 0, 8, 1, 0, 0, 0);
    check("chain2_release", int'(stall_if_id), 0);
    check("chain_count", int'(stall_count), 3);
    nop();

    for (int i = 0; i < 12; i++) one_load_stall();
    check("count_full", int'(stall_count), 15);
    one_load_stall();
    check("count_sat", int'(stall_count), 15);

    // reset in the middle of a stall
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 8, 1, 0, 7, 1, 0, 0, 0);
    #1;
    check("mid_stall_on", int'(stall_if_id), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fwd_a", int'(fwd_a_sel), 0);
    check("mid_rst_fwd_b", int'(fwd_b_sel), 0);
    check("mid_rst_stall", int'(stall_if_id), 0);
    check("mid_rst_bubble", int'(bubble_ex), 0);
    check("mid_rst_count", int'(stall_count), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1, 8, 1, 0, 7, 1, 0, 0, 0);
    check("after_rst_stall", int'(stall_if_id), 0);
    nop();
    nop();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
